// File: rtl/bcd_updown_counter_n.sv
// Multi-digit BCD up/down counter with enable, synchronous clear, validated
// parallel load, terminal-count output and a wrap/saturate event pulse.
// Digit i lives in bits [4i+3:4i]; digit 0 is least significant.
module bcd_updown_counter_n #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  sclr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  tc,
    output logic                  ovf,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0] count_next;
    logic         all_nine;
    logic         all_zero;
    logic         load_ok;
    logic         at_term;
    logic         ripple;
    logic [3:0]   digit;

    // Decode the current count for terminal detection and check load digits are BCD
    always_comb begin
        all_nine = 1'b1;
        all_zero = 1'b1;
        load_ok  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (Q[4*i +: 4] != 4'd9) all_nine = 1'b0;
            if (Q[4*i +: 4] != 4'd0) all_zero = 1'b0;
            if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
        end
    end

    assign at_term = up_dn ? all_nine : all_zero;
    assign tc      = en & at_term;

    // Ripple a carry (up) or borrow (down) through the decades, starting at digit 0
    always_comb begin
        count_next = Q;
        ripple     = 1'b1;
        digit      = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = Q[4*i +: 4];
            if (ripple) begin
                if (up_dn) begin
                    count_next[4*i +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
                    ripple               = (digit == 4'd9);
                end else begin
                    count_next[4*i +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
                    ripple               = (digit == 4'd0);
                end
            end
        end
    end

    // Count register and event pulses; priority is clear, then load, then count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q        <= '0;
            ovf      <= 1'b0;
            load_err <= 1'b0;
        end else if (sclr) begin
            Q        <= '0;
            ovf      <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            if (load_ok) Q <= load_val;
            ovf      <= 1'b0;
            load_err <= ~load_ok;
        end else if (en) begin
            // In saturate mode the count parks at the terminal value but still flags the event
            if (!(at_term && !WRAP)) Q <= count_next;
            ovf      <= at_term;
            load_err <= 1'b0;
        end else begin
            ovf      <= 1'b0;
            load_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Directed bench for bcd_updown_counter_n: three instances (2-digit wrap,
// 2-digit saturate, 4-digit wrap) share control inputs; expected results are
// queued as stimulus is driven and compared when the DUT has responded.
module tb_bcd_updown_counter_n;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, up_dn, sclr, load;
    logic [7:0]  lv2;
    logic [15:0] lv4;

    logic [7:0]  q_w2, q_s2;
    logic [15:0] q_w4;
    logic        tc_w2, tc_s2, tc_w4;
    logic        ovf_w2, ovf_s2, ovf_w4;
    logic        le_w2, le_s2, le_w4;

    int checks = 0;
    int passed = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] q;
        logic        ovf;
        logic        lerr;
        logic        tc;
    } exp_t;

    exp_t sb[$];

    localparam int W2 = 0;
    localparam int S2 = 1;
    localparam int W4 = 2;

    bcd_updown_counter_n #(.DIGITS(2), .WRAP(1'b1)) u_w2 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .sclr(sclr), .load(load),
        .load_val(lv2), .Q(q_w2), .tc(tc_w2), .ovf(ovf_w2), .load_err(le_w2)
    );

    bcd_updown_counter_n #(.DIGITS(2), .WRAP(1'b0)) u_s2 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .sclr(sclr), .load(load),
        .load_val(lv2), .Q(q_s2), .tc(tc_s2), .ovf(ovf_s2), .load_err(le_s2)
    );

    bcd_updown_counter_n #(.DIGITS(4), .WRAP(1'b1)) u_w4 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .sclr(sclr), .load(load),
        .load_val(lv4), .Q(q_w4), .tc(tc_w4), .ovf(ovf_w4), .load_err(le_w4)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // Decimal value to packed BCD by repeated division
    function automatic logic [31:0] to_bcd(int v);
        logic [31:0] r;
        int          n;
        r = '0;
        n = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic drv(logic e, logic u, logic sc, logic ld, logic [7:0] v2, logic [15:0] v4);
        en    = e;
        up_dn = u;
        sclr  = sc;
        load  = ld;
        lv2   = v2;
        lv4   = v4;
    endtask

    task automatic push(string tag, int sel, logic [31:0] q, logic o, logic l, logic t);
        exp_t e;
        e.tag  = tag;
        e.sel  = sel;
        e.q    = q;
        e.ovf  = o;
        e.lerr = l;
        e.tc   = t;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare it against the selected instance now
    task automatic check_now();
        exp_t        e;
        logic [31:0] oq;
        logic        oo, ol, ot;
        if (sb.size() == 0) begin
            checks++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        case (e.sel)
            W2:      begin oq = {24'b0, q_w2}; oo = ovf_w2; ol = le_w2; ot = tc_w2; end
            S2:      begin oq = {24'b0, q_s2}; oo = ovf_s2; ol = le_s2; ot = tc_s2; end
            default: begin oq = {16'b0, q_w4}; oo = ovf_w4; ol = le_w4; ot = tc_w4; end
        endcase
        chk({e.tag, ".Q"},        oq, e.q);
        chk({e.tag, ".ovf"},      {31'b0, oo}, {31'b0, e.ovf});
        chk({e.tag, ".load_err"}, {31'b0, ol}, {31'b0, e.lerr});
        chk({e.tag, ".tc"},       {31'b0, ot}, {31'b0, e.tc});
    endtask

    task automatic step(string tag, int sel, logic [31:0] q, logic o, logic l, logic t);
        push(tag, sel, q, o, l, t);
        @(posedge clk);
        #1;
        check_now();
    endtask

    initial begin
        reset = 1'b1;
        drv(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        // Reset holds everything at zero even with counting requested
        push("reset_w2", W2, 32'h00, 1'b0, 1'b0, 1'b0);
        check_now();
        push("reset_w4", W4, 32'h0000, 1'b0, 1'b0, 1'b0);
        check_now();
        reset = 1'b0;

        // Test 1: 2-digit up count through all 100 values and wrap
        for (int k = 1; k <= 100; k++) begin
            drv(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
            step($sformatf("up%0d", k), W2, to_bcd(k % 100), (k == 100), 1'b0, ((k % 100) == 99));
        end
        drv(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        step("up_idle", W2, 32'h00, 1'b0, 1'b0, 1'b0);

        // Test 2: load 10, count down through 0 and wrap to 99
        drv(1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 16'h0000);
        step("ld10", W2, 32'h10, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            drv(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
            step($sformatf("dn%0d", k), W2, to_bcd(10 - k), 1'b0, 1'b0, (k == 10));
        end
        step("dn_wrap", W2, 32'h99, 1'b1, 1'b0, 1'b0);

        // Test 3: saturating instance parks at terminal and re-pulses ovf
        drv(1'b0, 1'b1, 1'b0, 1'b1, 8'h98, 16'h0000);
        step("sat_ld98", S2, 32'h98, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        step("sat_up1", S2, 32'h99, 1'b0, 1'b0, 1'b1);
        step("sat_up2", S2, 32'h99, 1'b1, 1'b0, 1'b1);
        step("sat_up3", S2, 32'h99, 1'b1, 1'b0, 1'b1);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        step("sat_dn", S2, 32'h98, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000);
        step("sat_clr", S2, 32'h00, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        step("sat_lo1", S2, 32'h00, 1'b1, 1'b0, 1'b1);
        step("sat_lo2", S2, 32'h00, 1'b1, 1'b0, 1'b1);

        // Test 4: load validation on each digit
        drv(1'b0, 1'b1, 1'b0, 1'b1, 8'h31, 16'h0000);
        step("ld31", W2, 32'h31, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 16'h0000);
        step("ld5A_bad", W2, 32'h31, 1'b0, 1'b1, 1'b0);
        drv(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        step("lerr_clear", W2, 32'h31, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 16'h0000);
        step("ldA3_bad", W2, 32'h31, 1'b0, 1'b1, 1'b0);
        drv(1'b0, 1'b1, 1'b0, 1'b1, 8'h57, 16'h0000);
        step("ld57", W2, 32'h57, 1'b0, 1'b0, 1'b0);

        // Test 5: priority sclr > load > en
        drv(1'b1, 1'b1, 1'b1, 1'b1, 8'h42, 16'h0000);
        step("pri_clr", W2, 32'h00, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b1, 1'b0, 1'b1, 8'h42, 16'h0000);
        step("pri_ld", W2, 32'h42, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        step("pri_cnt", W2, 32'h43, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b1, 1'b0, 1'b1, 8'hF0, 16'h0000);
        step("pri_bad", W2, 32'h43, 1'b0, 1'b1, 1'b0);
        drv(1'b0, 1'b1, 1'b1, 1'b1, 8'hF0, 16'h0000);
        step("pri_clrbad", W2, 32'h00, 1'b0, 1'b0, 1'b0);

        // Test 6: 4-digit carry across three digits, then asynchronous reset mid-cycle
        drv(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 16'h0999);
        step("w4_ld0999", W4, 32'h0999, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        step("w4_up1000", W4, 32'h1000, 1'b0, 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        push("async_w4", W4, 32'h0000, 1'b0, 1'b0, 1'b0);
        check_now();
        push("async_w2", W2, 32'h00, 1'b0, 1'b0, 1'b0);
        check_now();
        @(posedge clk);
        #1;
        push("async_hold", W4, 32'h0000, 1'b0, 1'b0, 1'b0);
        check_now();
        reset = 1'b0;
        step("w4_first", W4, 32'h0001, 1'b0, 1'b0, 1'b0);

        // 4-digit terminal count and wrap from 9999
        drv(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 16'h9999);
        step("w4_ld9999", W4, 32'h9999, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        #1;
        push("w4_tc", W4, 32'h9999, 1'b0, 1'b0, 1'b1);
        check_now();
        step("w4_wrap", W4, 32'h0000, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
